// File: rtl/bcd_seg_scan.sv
`timescale 1ns/1ps
// Three-digit, common-anode seven-segment scanner fed by a packed BCD word.
// New values are committed only at frame boundaries, so a frame never mixes old and new digits.
module bcd_seg_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic        ld_ack,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    generate
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("bcd_seg_scan: SCAN_DIV must be >= 2");
        end
    endgenerate

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    dig, dig_n;
    logic [11:0]   disp, disp_n, pend;
    logic          pend_valid;
    logic          wrap, commit, ack_n, blank_dig;
    logic [3:0]    nib;
    logic [2:0]    an_n;
    logic [6:0]    seg_n;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'd0:    encode = 7'h40;
            4'd1:    encode = 7'h79;
            4'd2:    encode = 7'h24;
            4'd3:    encode = 7'h30;
            4'd4:    encode = 7'h19;
            4'd5:    encode = 7'h12;
            4'd6:    encode = 7'h02;
            4'd7:    encode = 7'h78;
            4'd8:    encode = 7'h00;
            4'd9:    encode = 7'h10;
            default: encode = 7'h3F;
        endcase
    endfunction

    // Outputs are registered from the next-cycle scan position so an/seg line up with cnt/dig.
    always_comb begin
        wrap    = (state == DRIVE) && (cnt == LAST);
        commit  = wrap && (dig == 2'd2);
        cnt_n   = wrap ? '0 : cnt + CW'(1);
        dig_n   = dig;
        if (wrap) dig_n = (dig == 2'd2) ? 2'd0 : dig + 2'd1;
        state_n = wrap ? BLANK : DRIVE;

        disp_n = disp;
        ack_n  = 1'b0;
        if (commit) begin
            if (load) begin
                disp_n = bcd_in;
                ack_n  = 1'b1;
            end else if (pend_valid) begin
                disp_n = pend;
                ack_n  = 1'b1;
            end
        end

        case (dig_n)
            2'd0:    nib = disp_n[3:0];
            2'd1:    nib = disp_n[7:4];
            default: nib = disp_n[11:8];
        endcase

        // A dash is not a zero, so an invalid hundreds digit keeps the tens visible.
        blank_dig = 1'b0;
        if (blank_lz) begin
            if (dig_n == 2'd2)
                blank_dig = (disp_n[11:8] == 4'd0);
            else if (dig_n == 2'd1)
                blank_dig = (disp_n[11:8] == 4'd0) && (disp_n[7:4] == 4'd0);
        end

        an_n  = 3'b111;
        seg_n = 7'h7F;
        if (state_n == DRIVE) begin
            an_n  = ~(3'b001 << dig_n);
            seg_n = blank_dig ? 7'h7F : encode(nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            dig        <= 2'd0;
            disp       <= 12'h000;
            pend       <= 12'h000;
            pend_valid <= 1'b0;
            ld_ack     <= 1'b0;
            an         <= 3'b111;
            seg        <= 7'h7F;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            dig    <= dig_n;
            disp   <= disp_n;
            ld_ack <= ack_n;
            an     <= an_n;
            seg    <= seg_n;
            if (commit) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend       <= bcd_in;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
`timescale 1ns/1ps
// Bench for bcd_seg_scan: a cycle model pushes expected outputs, sampled values are popped and compared.
module tb_bcd_seg_scan;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bcd_in = 12'h000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        ld_ack;
    logic [2:0]  an;
    logic [6:0]  seg;

    typedef struct packed {
        logic       ack;
        logic [2:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          m_cnt, m_dig;
    logic [11:0] m_disp, m_pend;
    logic        m_pv;

    bcd_seg_scan #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
        .ld_ack(ld_ack), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] segOf(input logic [3:0] n);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (n > 4'd9) ? 7'h3F : tbl[n];
    endfunction

    function automatic exp_t modelOut(input logic blz, input logic ack);
        exp_t       e;
        logic [3:0] n;
        logic       blk;
        e.ack = ack;
        e.an  = 3'b111;
        e.seg = 7'h7F;
        if (m_cnt != 0) begin
            e.an[m_dig] = 1'b0;
            n   = m_disp[m_dig*4 +: 4];
            blk = blz && (m_disp[11:8] == 4'd0) && (m_dig == 2 || (m_dig == 1 && m_disp[7:4] == 4'd0));
            e.seg = blk ? 7'h7F : segOf(n);
        end
        return e;
    endfunction

    task automatic compareHead();
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 12'd0, 12'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("an", an, e.an);
            checkOutput("seg", seg, e.seg);
            checkOutput("ld_ack", ld_ack, e.ack);
        end
    endtask

    task automatic resetModel();
        m_cnt  = 0;
        m_dig  = 0;
        m_disp = 12'h000;
        m_pend = 12'h000;
        m_pv   = 1'b0;
        sb.delete();
        sb.push_back(modelOut(1'b0, 1'b0));
    endtask

    task automatic applyStimulus(input logic ld, input logic [11:0] v, input logic blz);
        logic last, commit, ack;
        load     = ld;
        bcd_in   = v;
        blank_lz = blz;
        last   = (m_cnt == SD - 1);
        commit = last && (m_dig == 2);
        ack    = commit && (ld || m_pv);
        if (commit) begin
            if (ld) m_disp = v;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_pv   = 1'b1;
        end
        m_cnt = last ? 0 : m_cnt + 1;
        if (last) m_dig = (m_dig + 1) % 3;
        sb.push_back(modelOut(blz, ack));
        @(negedge clk);
        cyc++;
        compareHead();
        load = 1'b0;
    endtask

    task automatic idleTo(input int target, input logic blz);
        while (cyc < target) applyStimulus(1'b0, 12'h000, blz);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        resetModel();
        compareHead();
        checkOutput("rst_an", an, 3'b111);
        checkOutput("rst_seg", seg, 7'h7F);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        releaseReset();

        // Reset release scan and a single load
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("c1_an", an, 3'b110);
        checkOutput("c1_seg", seg, 7'h40);
        idleTo(2, 1'b0);
        applyStimulus(1'b1, 12'h255, 1'b0);
        idleTo(12, 1'b0);
        checkOutput("load255_ack", ld_ack, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("load255_ack_off", ld_ack, 1'b0);
        checkOutput("load255_ones", seg, 7'h12);
        idleTo(24, 1'b0);

        // Two loads in one frame, newest wins, then leading-zero blanking
        idleTo(26, 1'b0);
        applyStimulus(1'b1, 12'h123, 1'b0);
        idleTo(28, 1'b0);
        applyStimulus(1'b1, 12'h007, 1'b0);
        idleTo(30, 1'b0);
        idleTo(36, 1'b1);
        checkOutput("dbl_ack", ld_ack, 1'b1);
        idleTo(41, 1'b1);
        checkOutput("lz_tens_an", an, 3'b101);
        checkOutput("lz_tens_seg", seg, 7'h7F);
        idleTo(45, 1'b1);
        checkOutput("lz_hund_an", an, 3'b011);
        checkOutput("lz_hund_seg", seg, 7'h7F);
        idleTo(48, 1'b1);

        // Load in the commit cycle bypasses pending
        idleTo(59, 1'b0);
        applyStimulus(1'b1, 12'h099, 1'b0);
        checkOutput("bypass_ack", ld_ack, 1'b1);
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("bypass_ones", seg, 7'h10);
        idleTo(72, 1'b0);
        checkOutput("bypass_no_2nd_ack", ld_ack, 1'b0);

        // Invalid nibbles show a dash and are never blanked
        applyStimulus(1'b1, 12'h0A5, 1'b1);
        idleTo(84, 1'b1);
        checkOutput("a5_ack", ld_ack, 1'b1);
        idleTo(85, 1'b1);
        checkOutput("a5_ones", seg, 7'h12);
        idleTo(89, 1'b1);
        checkOutput("a5_tens_dash", seg, 7'h3F);
        idleTo(93, 1'b1);
        checkOutput("a5_hund_an", an, 3'b011);
        checkOutput("a5_hund_blank", seg, 7'h7F);
        applyStimulus(1'b1, 12'hB00, 1'b1);
        idleTo(97, 1'b1);
        checkOutput("b00_ones", seg, 7'h40);
        idleTo(101, 1'b1);
        checkOutput("b00_tens", seg, 7'h40);
        idleTo(105, 1'b1);
        checkOutput("b00_hund_dash", seg, 7'h3F);
        idleTo(108, 1'b1);

        // Asynchronous reset mid-DRIVE with a pending value
        applyStimulus(1'b1, 12'h321, 1'b0);
        idleTo(110, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_an", an, 3'b111);
        checkOutput("async_seg", seg, 7'h7F);
        checkOutput("async_ack", ld_ack, 1'b0);
        @(posedge clk);
        releaseReset();
        idleTo(12, 1'b0);
        checkOutput("post_rst_no_ack", ld_ack, 1'b0);
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("post_rst_ones", seg, 7'h40);
        checkOutput("post_rst_an", an, 3'b110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
